// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int         MIN_DATA_LEN = 5;
    localparam logic [1:0] PAR_NONE2    = 2'b11;

    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:     return PAR_EVEN;
            2'b10:     return PAR_ODD;
            PAR_NONE2: return PAR_NONE;
            default:   return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous write FIFO feeding the UART framer; head word is
// visible combinationally so the framer can latch it on the pop edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              overflow
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              do_push;
    logic              do_pop;

    // A write against the registered full flag is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(FIFO_DEPTH));
            empty <= (count_next == '0);
            if (push && full) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: FIFO plus a framing FSM whose baud divisor,
// data length, parity and stop bits are latched per frame at the pop.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic [DIV_W-1:0]             baud_div,
    input  logic [3:0]                   data_len,
    input  logic [1:0]                   parity_mode,
    input  logic                         stop2,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         clr_ovf,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         overflow,
    output logic                         tx_serial
);

    localparam logic [3:0] MAX_LEN = 4'(DATA_W);
    localparam logic [3:0] MIN_LEN = 4'(MIN_DATA_LEN);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [DIV_W-1:0]  baud_cnt;
    logic [DIV_W-1:0]  cnt_next;
    logic [DIV_W-1:0]  frame_div;
    logic [DIV_W-1:0]  div_in;
    logic [3:0]        bit_idx;
    logic [3:0]        idx_next;
    logic [3:0]        frame_len;
    logic [3:0]        len_in;
    logic [DATA_W-1:0] frame_data;
    logic [DATA_W-1:0] head;
    logic [15:0]       data_ext;
    parity_t           frame_par;
    logic              frame_stop2;
    logic              pop;
    logic              bit_end;
    logic              last_data;
    logic              par_bit;
    logic              tx_d;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nRst      (nRst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .clr_ovf   (clr_ovf),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    always_comb begin
        div_in = (baud_div == '0) ? DIV_W'(1) : baud_div;
        if (data_len < MIN_LEN)      len_in = MIN_LEN;
        else if (data_len > MAX_LEN) len_in = MAX_LEN;
        else                         len_in = data_len;
    end

    assign data_ext  = 16'(frame_data);
    assign bit_end   = (baud_cnt == frame_div - 1'b1);
    assign last_data = (bit_idx == frame_len - 4'd1);

    // Only the low frame_len bits were transmitted, so only they feed parity.
    always_comb begin
        par_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < frame_len) par_bit = par_bit ^ data_ext[i];
        end
        if (frame_par == PAR_ODD) par_bit = ~par_bit;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            frame_data  <= '0;
            frame_div   <= '0;
            frame_len   <= '0;
            frame_par   <= PAR_NONE;
            frame_stop2 <= 1'b0;
            tx_serial   <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= cnt_next;
            bit_idx   <= idx_next;
            tx_serial <= tx_d;
            if (pop) begin
                frame_data  <= head;
                frame_div   <= div_in;
                frame_len   <= len_in;
                frame_par   <= decode_parity(parity_mode);
                frame_stop2 <= stop2;
            end
        end
    end

    // bit_idx doubles as the stop-bit counter in STOP.
    always_comb begin
        state_next = state;
        cnt_next   = baud_cnt;
        idx_next   = bit_idx;
        pop        = 1'b0;
        if (state != IDLE) cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        state_next = (frame_par == PAR_NONE) ? STOP : PARITY;
                        idx_next   = '0;
                    end else begin
                        idx_next = bit_idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    idx_next   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (frame_stop2 && bit_idx == 4'd0) begin
                        idx_next = 4'd1;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx_serial is registered, so its next value follows the next state.
    always_comb begin
        busy = (state != IDLE);
        tx_d = 1'b1;
        case (state_next)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_ext[idx_next];
            PARITY:  tx_d = par_bit;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: per-clock waveform capture compared
// against hand-written bit sequences expanded by the baud divisor.
module tb_uart_tx_frame;

    localparam int DATA_W     = 8;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              nRst = 1'b0;
    logic [DIV_W-1:0]  baud_div = '0;
    logic [3:0]        data_len = '0;
    logic [1:0]        parity_mode = '0;
    logic              stop2 = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clr_ovf = 1'b0;
    logic              full;
    logic              empty;
    logic [2:0]        fifo_count;
    logic              busy;
    logic              overflow;
    logic              tx_serial;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_W     (DATA_W),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .baud_div    (baud_div),
        .data_len    (data_len),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clr_ovf     (clr_ovf),
        .full        (full),
        .empty       (empty),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .overflow    (overflow),
        .tx_serial   (tx_serial)
    );

    // seq holds the bits in transmit order, first bit at position n-1.
    function automatic logic [127:0] expand(input logic [63:0] seq, input int n, input int div);
        logic [127:0] w = '0;
        for (int c = 0; c < n * div; c++) w[c] = seq[n - 1 - c / div];
        return w;
    endfunction

    task automatic set_cfg(input logic [15:0] div, input logic [3:0] len,
                           input logic [1:0] par, input logic s2);
        baud_div    = div;
        data_len    = len;
        parity_mode = par;
        stop2       = s2;
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic capture(input int n, output logic [127:0] wave, output int busy_hi);
        wave    = '0;
        busy_hi = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            wave[c] = tx_serial;
            if (busy) busy_hi++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (tx_serial !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx_serial); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if ({full, empty, overflow} !== 3'b010) begin
            errors++; $display("[TB] FAIL reset_flags: got full/empty/ovf %b expected 010", {full, empty, overflow});
        end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        nRst = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [127:0] w;
        logic [127:0] exp_w;
        int bh;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
        send_byte(8'hA5);
        capture(40, w, bh);
        exp_w = expand(64'b0101001011, 10, 4);
        checks++;
        if (w !== exp_w) begin errors++; $display("[TB] FAIL basic_wave: got %h expected %h", w, exp_w); end
        checks++;
        if (bh !== 40) begin errors++; $display("[TB] FAIL basic_busy: got %0d busy clocks expected 40", bh); end
        @(negedge clk);
        checks++;
        if ({tx_serial, busy} !== 2'b10) begin
            errors++; $display("[TB] FAIL basic_idle: got tx/busy %b expected 10", {tx_serial, busy});
        end
    endtask

    task automatic test_parity();
        logic [1:0]  modes [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
        logic [7:0]  bytes [4] = '{8'hA5, 8'h07, 8'hA5, 8'h07};
        logic [63:0] seqs  [4] = '{64'b01010010101, 64'b01110000011,
                                   64'b01010010111, 64'b01110000001};
        logic [127:0] w;
        logic [127:0] exp_w;
        int bh;
        for (int i = 0; i < 4; i++) begin
            set_cfg(16'd4, 4'd8, modes[i], 1'b0);
            send_byte(bytes[i]);
            capture(44, w, bh);
            exp_w = expand(seqs[i], 11, 4);
            checks++;
            if (w !== exp_w) begin
                errors++; $display("[TB] FAIL parity_wave[%0d]: got %h expected %h", i, w, exp_w);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("[TB] FAIL parity_len[%0d]: busy %b expected 0", i, busy); end
        end
    endtask

    task automatic test_stop2_short();
        logic [127:0] w;
        logic [127:0] exp_w;
        int bh;
        set_cfg(16'd2, 4'd5, 2'b00, 1'b1);
        send_byte(8'h3F);
        capture(16, w, bh);
        exp_w = expand(64'b01111111, 8, 2);
        checks++;
        if (w !== exp_w) begin errors++; $display("[TB] FAIL stop2_wave: got %h expected %h", w, exp_w); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop2_len: busy %b expected 0", busy); end
        // divisor 0 acts as 1, length 0 clamps up to 5
        set_cfg(16'd0, 4'd0, 2'b11, 1'b1);
        send_byte(8'h3F);
        capture(8, w, bh);
        exp_w = expand(64'b01111111, 8, 1);
        checks++;
        if (w !== exp_w) begin errors++; $display("[TB] FAIL clamp_wave: got %h expected %h", w, exp_w); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clamp_len: busy %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] w;
        logic [127:0] exp_w;
        int bh;
        set_cfg(16'd3, 4'd8, 2'b00, 1'b0);
        fork
            begin
                @(negedge clk); wr_en = 1'b1; wr_data = 8'h11;
                @(negedge clk); wr_data = 8'h22;
                @(negedge clk); wr_data = 8'h33;
                @(negedge clk); wr_en = 1'b0;
            end
            capture(92, w, bh);
        join
        exp_w = (expand(64'b010001000100100010010110011001, 30, 3) << 2) | 128'h3;
        checks++;
        if (w !== exp_w) begin errors++; $display("[TB] FAIL b2b_wave: got %h expected %h", w, exp_w); end
        checks++;
        if (bh !== 90) begin errors++; $display("[TB] FAIL b2b_busy: got %0d busy clocks expected 90", bh); end
        @(negedge clk);
        checks++;
        if ({empty, fifo_count, busy} !== 5'b1_000_0) begin
            errors++; $display("[TB] FAIL b2b_end: got empty/count/busy %b expected 100000", {empty, fifo_count, busy});
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        int busy_cnt = 0;
        set_cfg(16'd100, 4'd8, 2'b00, 1'b0);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk); wr_en = 1'b1; wr_data = vals[i];
                end
                @(negedge clk); wr_en = 1'b0;
                checks++;
                if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 4", fifo_count); end
                checks++;
                if ({full, overflow} !== 2'b11) begin
                    errors++; $display("[TB] FAIL ovf_flags: got full/ovf %b expected 11", {full, overflow});
                end
            end
            begin
                for (int c = 0; c < 7000; c++) begin
                    @(negedge clk);
                    if (busy) busy_cnt++;
                    else if (busy_cnt > 0) break;
                end
            end
        join
        checks++;
        if (busy_cnt !== 5000) begin errors++; $display("[TB] FAIL ovf_frames: got %0d busy clocks expected 5000", busy_cnt); end
        checks++;
        if ({full, empty, overflow} !== 3'b011) begin
            errors++; $display("[TB] FAIL ovf_sticky: got full/empty/ovf %b expected 011", {full, empty, overflow});
        end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] w;
        logic [127:0] exp_w;
        int bh;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk); wr_data = 8'h5A;
        @(negedge clk); wr_en = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre: busy %b expected 1", busy); end
        #2 nRst = 1'b0;
        #1;
        checks++;
        if ({tx_serial, busy, empty, fifo_count} !== 6'b1_0_1_000) begin
            errors++; $display("[TB] FAIL midrst_state: got tx/busy/empty/count %b expected 101000",
                                {tx_serial, busy, empty, fifo_count});
        end
        @(negedge clk); nRst = 1'b1;
        send_byte(8'hC3);
        capture(40, w, bh);
        exp_w = expand(64'b0110000111, 10, 4);
        checks++;
        if (w !== exp_w) begin errors++; $display("[TB] FAIL midrst_wave: got %h expected %h", w, exp_w); end
        @(negedge clk);
        checks++;
        if ({busy, empty} !== 2'b01) begin
            errors++; $display("[TB] FAIL midrst_idle: got busy/empty %b expected 01", {busy, empty});
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_stop2_short();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised, buffered UART transmitter and next-generation serial TX block for the team's peripheral set. Small write FIFO in front of a framing FSM. Frame shape is runtime-configurable per frame: baud divisor, data width up to DATA_W, parity none/even/odd, 1 or 2 stop bits. Back-to-back frames are sent with no idle gap while the FIFO holds data; sticky overflow flags dropped writes.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9); FIFO entry width
DIV_W, 16, width of runtime baud divisor
FIFO_DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
baud_div  in  DIV_W  clocks per bit; 0 treated as 1
data_len  in  4  data bits per frame; values below 5 or above DATA_W clamp to that bound
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
stop2  in  1  1 = two stop bits, 0 = one
wr_en  in  1  write strobe; pushes wr_data when not full
wr_data  in  DATA_W  byte to send, LSB transmitted first
clr_ovf  in  1  clears overflow
full  out  1  FIFO full (registered)
empty  out  1  FIFO empty (registered)
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
busy  out  1  high in every state except IDLE
overflow  out  1  sticky: write attempted while full
tx_serial  out  1  serial line, registered, idles high

Behaviour:
- Reset (async, any state, including mid-frame): tx_serial=1, busy=0, full=0, empty=1, fifo_count=0, overflow=0, FSM=IDLE, all counters 0, FIFO contents discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit period: every non-IDLE state holds each bit exactly max(baud_div,1) clocks. Baud counter runs 0..div-1; bit ends when counter==div-1.
- IDLE: tx_serial=1. If !empty: pop head, latch byte, baud_div, data_len, parity_mode, stop2 into frame registers; next state START.
- Config inputs are sampled only at that pop; changes mid-frame do not affect the current frame.
- START: tx_serial=0 for one bit -> DATA, bit index 0.
- DATA: tx_serial=byte[idx]. At bit end, idx+1; after idx==len-1 go to PARITY if parity enabled, else STOP.
- PARITY: even -> XOR of transmitted data bits; odd -> inverted XOR. Only the low len bits count. One bit -> STOP.
- STOP: tx_serial=1 for 1 bit period, or 2 if stop2. At end: if !empty, pop and go directly to START (new config latched, zero idle cycles); else IDLE.
- Latency: wr_en at edge k into an empty FIFO while IDLE -> pop at edge k+1, tx_serial low from edge k+1.
- FIFO: write when wr_en && !full. Pop only by FSM. Simultaneous write and pop: both occur, count unchanged.
- wr_en while full is dropped, even if a pop happens the same cycle, and sets overflow. overflow clears on clr_ovf; set wins if both occur.
- Pointers wrap modulo FIFO_DEPTH. full/empty/fifo_count are updated from registered count.
- Frame length in clocks = div*(1+len+P+S), where P=1 if parity enabled and S=1 or 2.

Decomposition:
- Package uart_pkg:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - constants MIN_DATA_LEN=5, PAR_NONE2=2'b11
- Sub-module uart_tx_fifo: synchronous FIFO parametrised by DATA_W and FIFO_DEPTH, with push/pop/full/empty/count/overflow.
- uart_tx_frame holds the FSM, baud counter, bit index and frame registers.

Test Plan:
1. div=4, len=8, parity none, stop1; write 0xA5 -> tx_serial 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each 4 clocks, 40 clocks total; busy=1 throughout; then IDLE.
2. div=4, len=8, parity even, then odd; write 0xA5 then 0x07 -> parity bit 0 for 0xA5, 1 for 0x07 in even mode; inverted values in odd mode; frame 44 clocks.
3. div=2, len=5, stop2; write 0x3F -> data bits 1,1,1,1,1 (bit 5 ignored); two stop bits; frame 2*(1+5+2)=16 clocks.
4. div=3, write 3 bytes in consecutive cycles -> three frames back-to-back, tx_serial low on the clock right after the final stop bit, no idle cycles; empty=1 after third pop.
5. div=100, FIFO_DEPTH=4; write 6 bytes in consecutive cycles -> fifo_count=4, full=1, 6th byte dropped, overflow=1; exactly 5 frames sent; clr_ovf -> overflow=0.
6. Assert nRst low mid-DATA -> tx_serial=1, busy=0, empty=1 immediately; after release, a fresh write transmits a correct frame.
